// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ write-back sources.
// Optional macro RF_WRITE_FWD_EN adds same-cycle bypass of the pending registered write.
module rf_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 3,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [AW*NREQ-1:0] req_addr,
  input  logic [DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_wa,
  output logic [DW-1:0]      rf_wd,
  output logic [2:0]         grant_id,
  input  logic [AW-1:0]      rd_addr_a,
  input  logic [AW-1:0]      rd_addr_b,
  input  logic [DW-1:0]      rf_rd_a,
  input  logic [DW-1:0]      rf_rd_b,
  output logic [DW-1:0]      fwd_rd_a,
  output logic [DW-1:0]      fwd_rd_b
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [NREQ-1:0] gnt_p0;
  logic [PW-1:0]   gnt_idx_p0;
  logic            vld_p0;

  logic            vld_p1;
  logic [AW-1:0]   wa_p1;
  logic [DW-1:0]   wd_p1;
  logic [2:0]      gid_p1;

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[PW-1:0];
  endfunction

  // Stage p0: combinational grant, scanning from ptr with wrap-around
  always_comb begin
    gnt_p0     = '0;
    gnt_idx_p0 = '0;
    vld_p0     = 1'b0;
    if (!rst && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!vld_p0 && req_valid[rr_index(ptr, k)]) begin
          vld_p0     = 1'b1;
          gnt_idx_p0 = rr_index(ptr, k);
        end
      end
    end
    if (vld_p0) gnt_p0[gnt_idx_p0] = 1'b1;
  end

  assign req_ready = gnt_p0;
  assign ptr_nxt   = (gnt_idx_p0 == PW'(NREQ - 1)) ? '0 : gnt_idx_p0 + 1'b1;

  // Stage p1: registered write toward the register file; address/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      wa_p1  <= '0;
      wd_p1  <= '0;
      gid_p1 <= '0;
      ptr    <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        wa_p1  <= req_addr[AW*gnt_idx_p0 +: AW];
        wd_p1  <= req_data[DW*gnt_idx_p0 +: DW];
        gid_p1 <= 3'(gnt_idx_p0);
        ptr    <= ptr_nxt;
      end
    end
  end

  assign rf_we    = vld_p1;
  assign rf_wa    = wa_p1;
  assign rf_wd    = wd_p1;
  assign grant_id = gid_p1;

`ifdef RF_WRITE_FWD_EN
  // Bypass the write that commits at the next edge so decode sees fresh data
  assign fwd_rd_a = (vld_p1 && (wa_p1 == rd_addr_a)) ? wd_p1 : rf_rd_a;
  assign fwd_rd_b = (vld_p1 && (wa_p1 == rd_addr_b)) ? wd_p1 : rf_rd_b;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr_a, rd_addr_b};
  assign fwd_rd_a       = rf_rd_a;
  assign fwd_rd_b       = rf_rd_b;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: vector table plus hand sequences for forwarding and reset.
module tb_rf_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 3;
  localparam int DW   = 16;

`ifdef RF_WRITE_FWD_EN
  localparam logic [15:0] FWD_A = 16'hBEEF;
`else
  localparam logic [15:0] FWD_A = 16'h0000;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               hold;
  logic [NREQ-1:0]    req_valid;
  logic [AW*NREQ-1:0] req_addr;
  logic [DW*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rf_we;
  logic [AW-1:0]      rf_wa;
  logic [DW-1:0]      rf_wd;
  logic [2:0]         grant_id;
  logic [AW-1:0]      rd_addr_a;
  logic [AW-1:0]      rd_addr_b;
  logic [DW-1:0]      rf_rd_a;
  logic [DW-1:0]      rf_rd_b;
  logic [DW-1:0]      fwd_rd_a;
  logic [DW-1:0]      fwd_rd_b;

  always #5 clk = ~clk;

  rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .grant_id(grant_id),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b),
    .fwd_rd_a(fwd_rd_a), .fwd_rd_b(fwd_rd_b)
  );

  // Register file model fed by the arbiter's write port
  logic [15:0] rf_mem [8];
  always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;

  typedef struct {
    logic        r;
    logic        h;
    logic [2:0]  v;
    logic [8:0]  a;
    logic [47:0] d;
    logic [2:0]  rdy;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  gid;
  } vec_t;

  vec_t vecs[19];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic r, input logic h, input logic [2:0] v,
                              input logic [8:0] a, input logic [47:0] d,
                              input logic [2:0] rdy, input logic we, input logic [2:0] wa,
                              input logic [15:0] wd, input logic [2:0] gid);
    vec_t t;
    t.r = r; t.h = h; t.v = v; t.a = a; t.d = d;
    t.rdy = rdy; t.we = we; t.wa = wa; t.wd = wd; t.gid = gid;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t t, input int n);
    rst = t.r; hold = t.h; req_valid = t.v; req_addr = t.a; req_data = t.d;
    #1;
    chk($sformatf("v%0d_ready", n), 32'(req_ready), 32'(t.rdy));
    cyc();
    chk($sformatf("v%0d_we", n),  32'(rf_we),    32'(t.we));
    chk($sformatf("v%0d_wa", n),  32'(rf_wa),    32'(t.wa));
    chk($sformatf("v%0d_wd", n),  32'(rf_wd),    32'(t.wd));
    chk($sformatf("v%0d_gid", n), 32'(grant_id), 32'(t.gid));
  endtask

  localparam logic [8:0]  A_RR   = {3'd3, 3'd2, 3'd1};
  localparam logic [47:0] D_RR   = 48'h3333_2222_1111;
  localparam logic [8:0]  A_RACE = {3'd0, 3'd5, 3'd5};
  localparam logic [47:0] D_RACE = 48'h0000_BBBB_AAAA;
  localparam logic [8:0]  A_ONE  = {3'd7, 3'd0, 3'd0};
  localparam logic [47:0] D_ONE  = 48'h7777_0000_0000;
  localparam logic [8:0]  A_MIX  = {3'd6, 3'd2, 3'd1};
  localparam logic [47:0] D_MIX  = 48'h0606_0202_0101;

  initial begin
    rst = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; rf_rd_a = '0; rf_rd_b = '0;

    // reset, round robin, hold, idle
    vecs[0]  = mk(1'b1, 1'b0, 3'b111, A_RR, D_RR, 3'b000, 1'b0, 3'd0, 16'h0000, 3'd0);
    vecs[1]  = mk(1'b0, 1'b0, 3'b111, A_RR, D_RR, 3'b001, 1'b1, 3'd1, 16'h1111, 3'd0);
    vecs[2]  = mk(1'b0, 1'b0, 3'b111, A_RR, D_RR, 3'b010, 1'b1, 3'd2, 16'h2222, 3'd1);
    vecs[3]  = mk(1'b0, 1'b0, 3'b111, A_RR, D_RR, 3'b100, 1'b1, 3'd3, 16'h3333, 3'd2);
    vecs[4]  = mk(1'b0, 1'b0, 3'b111, A_RR, D_RR, 3'b001, 1'b1, 3'd1, 16'h1111, 3'd0);
    vecs[5]  = mk(1'b0, 1'b1, 3'b111, A_RR, D_RR, 3'b000, 1'b0, 3'd1, 16'h1111, 3'd0);
    vecs[6]  = mk(1'b0, 1'b1, 3'b111, A_RR, D_RR, 3'b000, 1'b0, 3'd1, 16'h1111, 3'd0);
    vecs[7]  = mk(1'b0, 1'b0, 3'b111, A_RR, D_RR, 3'b010, 1'b1, 3'd2, 16'h2222, 3'd1);
    vecs[8]  = mk(1'b0, 1'b0, 3'b000, A_RR, D_RR, 3'b000, 1'b0, 3'd2, 16'h2222, 3'd1);
    // reset then same-address race
    vecs[9]  = mk(1'b1, 1'b0, 3'b000, A_RR, D_RR, 3'b000, 1'b0, 3'd0, 16'h0000, 3'd0);
    vecs[10] = mk(1'b0, 1'b0, 3'b011, A_RACE, D_RACE, 3'b001, 1'b1, 3'd5, 16'hAAAA, 3'd0);
    vecs[11] = mk(1'b0, 1'b0, 3'b010, A_RACE, D_RACE, 3'b010, 1'b1, 3'd5, 16'hBBBB, 3'd1);
    // single requester back-to-back
    vecs[12] = mk(1'b0, 1'b0, 3'b100, A_ONE, D_ONE, 3'b100, 1'b1, 3'd7, 16'h7777, 3'd2);
    vecs[13] = mk(1'b0, 1'b0, 3'b100, A_ONE, D_ONE, 3'b100, 1'b1, 3'd7, 16'h7777, 3'd2);
    vecs[14] = mk(1'b0, 1'b0, 3'b000, A_ONE, D_ONE, 3'b000, 1'b0, 3'd7, 16'h7777, 3'd2);
    // sparse requesters, pointer wrap
    vecs[15] = mk(1'b0, 1'b0, 3'b101, A_MIX, D_MIX, 3'b001, 1'b1, 3'd1, 16'h0101, 3'd0);
    vecs[16] = mk(1'b0, 1'b0, 3'b101, A_MIX, D_MIX, 3'b100, 1'b1, 3'd6, 16'h0606, 3'd2);
    vecs[17] = mk(1'b0, 1'b0, 3'b110, A_MIX, D_MIX, 3'b010, 1'b1, 3'd2, 16'h0202, 3'd1);
    vecs[18] = mk(1'b0, 1'b0, 3'b110, A_MIX, D_MIX, 3'b100, 1'b1, 3'd6, 16'h0606, 3'd2);

    for (int i = 0; i < 19; i++) apply_vec(vecs[i], i);

    // Forwarding window: write to r4 pending while decode reads r4 (stale) and r3
    rst = 1'b0; hold = 1'b0;
    req_valid = 3'b001; req_addr = {3'd0, 3'd0, 3'd4}; req_data = 48'h0000_0000_BEEF;
    rd_addr_a = 3'd4; rd_addr_b = 3'd3; rf_rd_a = 16'h0000; rf_rd_b = 16'h1234;
    #1;
    chk("fwd_ready", 32'(req_ready), 32'(3'b001));
    chk("fwd_pre_a", 32'(fwd_rd_a), 32'(16'h0000));
    cyc();
    req_valid = 3'b000;
    #1;
    chk("fwd_we", 32'(rf_we), 32'(1'b1));
    chk("fwd_wa", 32'(rf_wa), 32'(3'd4));
    chk("fwd_a", 32'(fwd_rd_a), 32'(FWD_A));
    chk("fwd_b", 32'(fwd_rd_b), 32'(16'h1234));
    rd_addr_a = 3'd2;
    #1;
    chk("fwd_a_miss", 32'(fwd_rd_a), 32'(16'h0000));
    rd_addr_a = 3'd4;
    cyc();
    chk("fwd_after_we", 32'(rf_we), 32'(1'b0));
    chk("fwd_after_a", 32'(fwd_rd_a), 32'(16'h0000));
    chk("rf_r5_race", 32'(rf_mem[5]), 32'(16'hBBBB));
    chk("rf_r4", 32'(rf_mem[4]), 32'(16'hBEEF));

    // Reset mid-operation: grant req2, then reset discards it
    req_valid = 3'b100; req_addr = {3'd3, 3'd0, 3'd0}; req_data = 48'hC3C3_0000_0000;
    #1;
    chk("rst_mid_ready", 32'(req_ready), 32'(3'b100));
    cyc();
    chk("rst_mid_we", 32'(rf_we), 32'(1'b1));
    chk("rst_mid_gid", 32'(grant_id), 32'(3'd2));
    rst = 1'b1;
    #1;
    chk("rst_ready_low", 32'(req_ready), 32'(3'b000));
    cyc();
    chk("rst_we", 32'(rf_we), 32'(1'b0));
    chk("rst_wa", 32'(rf_wa), 32'(3'd0));
    chk("rst_wd", 32'(rf_wd), 32'(16'h0000));
    chk("rst_gid", 32'(grant_id), 32'(3'd0));
    rst = 1'b0;
    #1;
    chk("regrant_ready", 32'(req_ready), 32'(3'b100));
    cyc();
    chk("regrant_we", 32'(rf_we), 32'(1'b1));
    chk("regrant_wd", 32'(rf_wd), 32'(16'hC3C3));
    chk("regrant_gid", 32'(grant_id), 32'(3'd2));

    // Pointer returns to 0 on reset: advance it to 1, reset, then offer req0 and req1
    req_valid = 3'b001; req_addr = {3'd0, 3'd2, 3'd1}; req_data = 48'h0000_0B0B_0A0A;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; req_valid = 3'b011;
    #1;
    chk("ptr_rst_ready", 32'(req_ready), 32'(3'b001));
    cyc();
    chk("ptr_rst_gid", 32'(grant_id), 32'(3'd0));
    chk("ptr_rst_wd", 32'(rf_wd), 32'(16'h0A0A));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
